// File: rtl/sa_pe_mac.sv
// Output-stationary systolic MAC element: operands forwarded right/down in 1 cycle, tile result double-buffered.
// Result drains down the column on valid/ready; own word first, then ROW_IDX words from above; stalls hold data stable.
module sa_pe_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1,
  parameter int ROW_IDX    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_valid_in,
  input  logic                  a_last_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_valid_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_valid_out,
  output logic                  a_last_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_valid_out,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_valid_in,
  output logic                  psum_ready_out,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_valid_out,
  input  logic                  psum_ready_in,
  output logic                  overrun_o,
  output logic                  mismatch_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = 9;
  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam logic [CW-1:0] ROWS = CW'(ROW_IDX);
  localparam logic [ACC_WIDTH-1:0] MAX_V = IS_SIGNED ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] MIN_V = IS_SIGNED ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

  typedef enum logic [1:0] {S_ACC, S_EMIT, S_FWD} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   obuf;
  logic [ACC_WIDTH-1:0]   sum_sat;
  logic [PW-1:0]          a_x, b_x, prod;
  logic [ACC_WIDTH:0]     prod_x, acc_x, sum;
  logic                   fire, tile_end, dn_hs, up_hs, ret_acc, buf_free;

  // Extending both operands to PW bits makes the low PW product bits exact for either signedness.
  assign a_x    = {{DATA_WIDTH{IS_SIGNED & a_in[DATA_WIDTH-1]}}, a_in};
  assign b_x    = {{DATA_WIDTH{IS_SIGNED & b_in[DATA_WIDTH-1]}}, b_in};
  assign prod   = a_x * b_x;
  assign prod_x = {{(ACC_WIDTH+1-PW){IS_SIGNED & prod[PW-1]}}, prod};
  assign acc_x  = {IS_SIGNED & acc[ACC_WIDTH-1], acc};
  assign sum    = acc_x + prod_x;

  always_comb begin
    sum_sat = sum[ACC_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (IS_SIGNED) begin
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
          sum_sat = sum[ACC_WIDTH] ? MIN_V : MAX_V;
      end else if (sum[ACC_WIDTH]) begin
        sum_sat = MAX_V;
      end
    end
  end

  assign fire     = a_valid_in & b_valid_in;
  assign tile_end = fire & a_last_in & ~clear_i;
  assign dn_hs    = psum_valid_out & psum_ready_in;
  // Stop accepting once all upstream words are in, so a following drain from above is never swallowed.
  assign psum_ready_out = (state == S_FWD) && (cnt < ROWS) && (!psum_valid_out || psum_ready_in);
  assign up_hs    = psum_valid_in & psum_ready_out;
  assign ret_acc  = ((state == S_EMIT) && dn_hs && (ROW_IDX == 0)) ||
                    ((state == S_FWD) && dn_hs && (cnt == ROWS));
  assign buf_free = (state == S_ACC) || ret_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      a_last_out  <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      a_last_out  <= a_last_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (clear_i || tile_end)
      acc <= '0;
    else if (fire)
      acc <= sum_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_ACC;
      cnt            <= '0;
      obuf           <= '0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      overrun_o      <= 1'b0;
      mismatch_o     <= 1'b0;
    end else begin
      if (a_valid_in ^ b_valid_in)
        mismatch_o <= 1'b1;
      if (tile_end && !buf_free)
        overrun_o <= 1'b1;
      if (tile_end && buf_free)
        obuf <= sum_sat;

      case (state)
        S_ACC: ;
        S_EMIT: begin
          if (dn_hs) begin
            psum_valid_out <= 1'b0;
            cnt            <= '0;
            state          <= (ROW_IDX == 0) ? S_ACC : S_FWD;
          end else begin
            psum_out       <= obuf;
            psum_valid_out <= 1'b1;
          end
        end
        S_FWD: begin
          if (up_hs) begin
            psum_out       <= psum_in;
            psum_valid_out <= 1'b1;
            cnt            <= cnt + 1'b1;
          end else if (dn_hs) begin
            psum_valid_out <= 1'b0;
          end
          if (ret_acc)
            state <= S_ACC;
        end
        default: state <= S_ACC;
      endcase

      // A tile that ends as the buffer frees up is taken directly.
      if (tile_end && buf_free)
        state <= S_EMIT;
    end
  end

endmodule

// File: tb/tb_sa_pe_mac.sv
// Directed bench for sa_pe_mac: four parameterisations share stimulus; each phase starts from reset.
module tb_sa_pe_mac;

  logic        clk, rst_n, clear_i;
  logic [7:0]  a_in, b_in;
  logic        a_valid_in, a_last_in, b_valid_in;
  logic [31:0] psum_in;
  logic        psum_valid_in, psum_ready_in;

  logic [3:0]  av_o, al_o, bv_o, pr_o, pv_o, ov_o, mm_o;
  logic [7:0]  ao [4];
  logic [7:0]  bo [4];
  logic [31:0] ps_s, ps_r;
  logic [15:0] ps_u, ps_w;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sa_pe_mac #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(1), .ROW_IDX(0)) u_s (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(ao[0]), .a_valid_out(av_o[0]), .a_last_out(al_o[0]), .b_out(bo[0]), .b_valid_out(bv_o[0]),
    .psum_in(psum_in), .psum_valid_in(psum_valid_in), .psum_ready_out(pr_o[0]),
    .psum_out(ps_s), .psum_valid_out(pv_o[0]), .psum_ready_in(psum_ready_in),
    .overrun_o(ov_o[0]), .mismatch_o(mm_o[0]));

  sa_pe_mac #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1), .ROW_IDX(0)) u_u (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(ao[1]), .a_valid_out(av_o[1]), .a_last_out(al_o[1]), .b_out(bo[1]), .b_valid_out(bv_o[1]),
    .psum_in(16'h0), .psum_valid_in(1'b0), .psum_ready_out(pr_o[1]),
    .psum_out(ps_u), .psum_valid_out(pv_o[1]), .psum_ready_in(psum_ready_in),
    .overrun_o(ov_o[1]), .mismatch_o(mm_o[1]));

  sa_pe_mac #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0), .ROW_IDX(0)) u_w (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(ao[2]), .a_valid_out(av_o[2]), .a_last_out(al_o[2]), .b_out(bo[2]), .b_valid_out(bv_o[2]),
    .psum_in(16'h0), .psum_valid_in(1'b0), .psum_ready_out(pr_o[2]),
    .psum_out(ps_w), .psum_valid_out(pv_o[2]), .psum_ready_in(psum_ready_in),
    .overrun_o(ov_o[2]), .mismatch_o(mm_o[2]));

  sa_pe_mac #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(1), .ROW_IDX(2)) u_r (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(ao[3]), .a_valid_out(av_o[3]), .a_last_out(al_o[3]), .b_out(bo[3]), .b_valid_out(bv_o[3]),
    .psum_in(psum_in), .psum_valid_in(psum_valid_in), .psum_ready_out(pr_o[3]),
    .psum_out(ps_r), .psum_valid_out(pv_o[3]), .psum_ready_in(psum_ready_in),
    .overrun_o(ov_o[3]), .mismatch_o(mm_o[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic last);
    a_in = a; b_in = b; a_valid_in = 1'b1; b_valid_in = 1'b1; a_last_in = last;
    tick();
  endtask

  task automatic idle();
    a_valid_in = 1'b0; b_valid_in = 1'b0; a_last_in = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_i = 1'b0; a_valid_in = 1'b0; b_valid_in = 1'b0; a_last_in = 1'b0;
    a_in = '0; b_in = '0; psum_in = '0; psum_valid_in = 1'b0; psum_ready_in = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; clear_i = 1'b0; a_in = 8'd7; b_in = 8'd7; a_valid_in = 1'b1; b_valid_in = 1'b0;
    a_last_in = 1'b1; psum_in = 32'd5; psum_valid_in = 1'b1; psum_ready_in = 1'b1;
    #22;
    chk("rst_a_out", 32'(ao[0]), 32'd0);
    chk("rst_a_valid_out", 32'(av_o[0]), 32'd0);
    chk("rst_psum_valid", 32'(pv_o[0]), 32'd0);
    chk("rst_psum_out", ps_s, 32'd0);
    chk("rst_ready_out", 32'(pr_o[3]), 32'd0);
    chk("rst_mismatch", 32'(mm_o[0]), 32'd0);
    chk("rst_overrun", 32'(ov_o[0]), 32'd0);
    do_reset();

    // Signed 3*4 + (-2)*5 + 7*(-1) = -5
    pair(8'd3, 8'd4, 1'b0);
    chk("fwd_a", 32'(ao[0]), 32'd3);
    chk("fwd_b", 32'(bo[0]), 32'd4);
    pair(8'hFE, 8'd5, 1'b0);
    chk("fwd_a_neg", 32'(ao[0]), 32'hFE);
    pair(8'd7, 8'hFF, 1'b1);
    chk("fwd_last", 32'(al_o[0]), 32'd1);
    chk("emit_not_yet", 32'(pv_o[0]), 32'd0);
    idle();
    chk("fwd_valid_drop", 32'(av_o[0]), 32'd0);
    chk("signed_valid", 32'(pv_o[0]), 32'd1);
    chk("signed_result", ps_s, 32'hFFFF_FFFB);
    psum_ready_in = 1'b1;
    tick();
    chk("drain_done", 32'(pv_o[0]), 32'd0);

    // Unsigned 16-bit: 2 * 65025 = 130050
    do_reset();
    pair(8'hFF, 8'hFF, 1'b0);
    pair(8'hFF, 8'hFF, 1'b1);
    idle();
    chk("sat_valid", 32'(pv_o[1]), 32'd1);
    chk("sat_result", 32'(ps_u), 32'd65535);
    chk("wrap_result", 32'(ps_w), 32'd64514);
    chk("signed_m1sq", ps_s, 32'd2);

    // ROW_IDX=2 drain: own 10, then 20, 30 with ready toggling
    do_reset();
    pair(8'd5, 8'd2, 1'b1);
    idle();
    chk("r2_own_valid", 32'(pv_o[3]), 32'd1);
    chk("r2_own_data", ps_r, 32'd10);
    chk("r2_no_ready_emit", 32'(pr_o[3]), 32'd0);
    psum_valid_in = 1'b1; psum_in = 32'd20;
    tick();
    chk("r2_stall_data", ps_r, 32'd10);
    chk("r2_stall_valid", 32'(pv_o[3]), 32'd1);
    psum_ready_in = 1'b1;
    tick();
    chk("r2_own_taken", 32'(pv_o[3]), 32'd0);
    chk("r2_fwd_ready", 32'(pr_o[3]), 32'd1);
    psum_ready_in = 1'b0;
    tick();
    chk("r2_w20", ps_r, 32'd20);
    chk("r2_w20_valid", 32'(pv_o[3]), 32'd1);
    chk("r2_ready_stall", 32'(pr_o[3]), 32'd0);
    psum_in = 32'd30;
    psum_ready_in = 1'b1;
    tick();
    chk("r2_w30", ps_r, 32'd30);
    psum_valid_in = 1'b0;
    psum_ready_in = 1'b0;
    tick();
    chk("r2_w30_stall", ps_r, 32'd30);
    chk("r2_w30_valid", 32'(pv_o[3]), 32'd1);
    psum_ready_in = 1'b1;
    tick();
    chk("r2_done_valid", 32'(pv_o[3]), 32'd0);
    chk("r2_done_ready", 32'(pr_o[3]), 32'd0);
    psum_ready_in = 1'b0;
    pair(8'd1, 8'd1, 1'b1);
    chk("r2_back_in_acc", 32'(ov_o[3]), 32'd0);
    idle();
    chk("r2_next_tile", ps_r, 32'd1);

    // Overrun: two 1-pair tiles, no downstream ready
    do_reset();
    pair(8'd1, 8'd2, 1'b1);
    pair(8'd3, 8'd4, 1'b1);
    chk("ovr_set", 32'(ov_o[0]), 32'd1);
    idle();
    chk("ovr_held_data", ps_s, 32'd2);
    chk("ovr_held_valid", 32'(pv_o[0]), 32'd1);

    // Clear wins over a fire; then a lone a_valid must not accumulate
    do_reset();
    clear_i = 1'b1;
    pair(8'd9, 8'd9, 1'b0);
    clear_i = 1'b0;
    pair(8'd1, 8'd1, 1'b1);
    idle();
    chk("clear_result", ps_s, 32'd1);
    psum_ready_in = 1'b1;
    tick();
    psum_ready_in = 1'b0;
    chk("mm_clean", 32'(mm_o[0]), 32'd0);
    a_in = 8'd5; a_valid_in = 1'b1; b_valid_in = 1'b0; a_last_in = 1'b0;
    tick();
    chk("mm_set", 32'(mm_o[0]), 32'd1);
    pair(8'd2, 8'd2, 1'b1);
    idle();
    chk("mm_no_acc", ps_s, 32'd4);
    chk("mm_sticky", 32'(mm_o[0]), 32'd1);

    // Reset in the middle of a forward
    do_reset();
    pair(8'd2, 8'd2, 1'b1);
    idle();
    psum_ready_in = 1'b1;
    tick();
    chk("mid_in_fwd", 32'(pr_o[3]), 32'd1);
    psum_valid_in = 1'b1; psum_in = 32'd77; psum_ready_in = 1'b0;
    tick();
    chk("mid_w77", ps_r, 32'd77);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(pv_o[3]), 32'd0);
    chk("mid_rst_data", ps_r, 32'd0);
    chk("mid_rst_ready", 32'(pr_o[3]), 32'd0);
    chk("mid_rst_bvalid", 32'(bv_o[3]), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_ignore_above", 32'(pr_o[3]), 32'd0);
    psum_valid_in = 1'b0;
    pair(8'd2, 8'd3, 1'b1);
    idle();
    chk("mid_after_valid", 32'(pv_o[3]), 32'd1);
    chk("mid_after_data", ps_r, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
